// File: rtl/vector_norm_multi.sv
// Multi-mode vector norm engine: L1, L2, Linf and squared L2 over LANES unsigned lanes.
// Lanes are folded into an accumulator one per cycle; L2 then runs a restoring square root.
module vector_norm_multi #(
   parameter int WIDTH = 4,
   parameter int LANES = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [1:0]                        mode,
   input  logic [LANES*WIDTH-1:0]            V_in,
   output logic                              busy,
   output logic [2*WIDTH+$clog2(LANES)-1:0]  norm_out,
   output logic                              done
);

   localparam int LANE_BITS = $clog2(LANES);
   localparam int SUM_BITS  = 2*WIDTH + LANE_BITS;
   localparam int ROOT_BITS = (SUM_BITS + 1) / 2;
   localparam int RW        = 2*ROOT_BITS;
   localparam int IDX_BITS  = $clog2(LANES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SQRT  = 2'd2
   } state_t;

   state_t                    state_q;
   logic [LANES*WIDTH-1:0]    vec_q;
   logic [1:0]                mode_q;
   logic [SUM_BITS-1:0]       acc_q;
   logic [SUM_BITS-1:0]       acc_d;
   logic [IDX_BITS-1:0]       idx_q;
   logic [RW-1:0]             rem_q;
   logic [RW-1:0]             rem_d;
   logic [RW-1:0]             root_q;
   logic [RW-1:0]             root_d;
   logic [RW-1:0]             bit_q;
   logic [RW-1:0]             trial;
   logic [SUM_BITS-1:0]       norm_q;
   logic                      busy_q;
   logic                      done_q;
   logic [WIDTH-1:0]          lane_sel;
   logic [SUM_BITS-1:0]       lane_ext;

   always_comb begin
      lane_sel = '0;
      for (int i = 0; i < LANES; i++) begin
         if (idx_q == IDX_BITS'(i)) lane_sel = vec_q[i*WIDTH +: WIDTH];
      end
      lane_ext = SUM_BITS'(lane_sel);

      case (mode_q)
         2'd0:    acc_d = acc_q + lane_ext;
         2'd2:    acc_d = (lane_ext > acc_q) ? lane_ext : acc_q;
         default: acc_d = acc_q + lane_ext * lane_ext;
      endcase

      trial = root_q + bit_q;
      if (rem_q >= trial) begin
         rem_d  = rem_q - trial;
         root_d = (root_q >> 1) + bit_q;
      end else begin
         rem_d  = rem_q;
         root_d = root_q >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         vec_q   <= '0;
         mode_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         bit_q   <= '0;
         norm_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               if (start) begin
                  vec_q   <= V_in;
                  mode_q  <= mode;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               // idx == LANES is the extra finishing cycle after the last lane
               if (idx_q == IDX_BITS'(LANES)) begin
                  if (mode_q == 2'd1) begin
                     rem_q   <= RW'(acc_q);
                     root_q  <= '0;
                     bit_q   <= RW'(1) << (RW - 2);
                     busy_q  <= 1'b1;
                     state_q <= SQRT;
                  end else begin
                     norm_q  <= acc_q;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else begin
                  acc_q  <= acc_d;
                  idx_q  <= idx_q + IDX_BITS'(1);
                  busy_q <= 1'b1;
               end
            end
            SQRT: begin
               rem_q  <= rem_d;
               root_q <= root_d;
               bit_q  <= bit_q >> 2;
               // bit reaches 1 on the last of the ROOT_BITS iterations
               if (bit_q == RW'(1)) begin
                  norm_q  <= SUM_BITS'(root_d);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  busy_q <= 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign norm_out = norm_q;

endmodule

// File: tb/tb_vector_norm_multi.sv
// Scoreboard bench for vector_norm_multi: the driver queues expected results from an
// arithmetic reference model, a negedge monitor checks done, norm_out, latency and busy.
module tb_vector_norm_multi;

   localparam int W   = 4;
   localparam int L   = 4;
   localparam int SB  = 2*W + $clog2(L);
   localparam int RB  = (SB + 1) / 2;
   localparam int N   = L*W;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [N-1:0]  V_in = '0;
   logic          busy;
   logic [SB-1:0] norm_out;
   logic          done;

   vector_norm_multi #(.WIDTH(W), .LANES(L)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .V_in     (V_in),
      .busy     (busy),
      .norm_out (norm_out),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int val;
      int k;
      int dc;
      int m;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   norm_exp = 0;
   int   last_done = 0;
   int   txn = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference: norm straight from the definitions, square root by search.
   function automatic int ref_norm(input int m, input logic [N-1:0] v);
      int s;
      int r;
      s = 0;
      for (int i = 0; i < L; i++) begin
         int x;
         x = int'(v[i*W +: W]);
         if (m == 0) s += x;
         else if (m == 2) s = (x > s) ? x : s;
         else s += x*x;
      end
      if (m != 1) return s;
      r = 0;
      while ((r+1)*(r+1) <= s) r++;
      return r;
   endfunction

   function automatic logic [N-1:0] pack(input int l0, input int l1, input int l2, input int l3);
      logic [N-1:0] v;
      v = '0;
      v[0*W +: W] = W'(l0);
      v[1*W +: W] = W'(l1);
      v[2*W +: W] = W'(l2);
      v[3*W +: W] = W'(l3);
      return v;
   endfunction

   function automatic logic [N-1:0] rand_vec();
      logic [N-1:0] v;
      for (int i = 0; i < L; i++) v[i*W +: W] = W'($urandom_range(0, (1<<W)-1));
      return v;
   endfunction

   // Called at posedge+1; starts as soon as the DUT is idle (the done cycle counts as idle).
   task automatic issue(input int m, input logic [N-1:0] v, input bit scr_full);
      exp_t e;
      while (cyc < last_done) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      mode  = 2'(m);
      V_in  = v;
      e.m   = m;
      e.val = ref_norm(m, v);
      e.k   = cyc + 1;
      e.dc  = e.k + ((m == 1) ? (L + RB + 1) : (L + 1));
      q.push_back(e);
      last_done = e.dc;
      @(posedge clk); #1;
      start = 1'b0;
      mode  = 2'($urandom_range(0, 3));
      V_in  = scr_full ? {N{1'b1}} : rand_vec();
   endtask

   task automatic spurious_start();
      if (cyc + 1 <= last_done) begin
         start = 1'b1;
         mode  = 2'($urandom_range(0, 3));
         V_in  = rand_vec();
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Monitor
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               txn++;
               $display("txn %0d mode=%0d start@%0d done@%0d norm_out=%0d expected=%0d",
                        txn, e.m, e.k, cyc, norm_out, e.val);
               chk("done_value", int'(norm_out), e.val);
               chk("done_latency", cyc - e.k, e.dc - e.k);
               norm_exp = e.val;
            end
         end else if (q.size() > 0 && cyc >= q[0].dc) begin
            exp_t e;
            e = q.pop_front();
            chk("missing_done", 0, 1);
            norm_exp = e.val;
         end
         chk("norm_hold", int'(norm_out), norm_exp);
         chk("busy", int'(busy),
             int'(q.size() > 0 && cyc >= q[0].k + 1 && cyc < q[0].dc));
      end
   end

   // Driver
   initial begin
      int wait_cnt;
      reset = 1'b1;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      reset = 1'b0;
      last_done = cyc;

      issue(1, pack(3, 4, 0, 0), 1'b0);
      issue(0, pack(15, 15, 15, 15), 1'b0);
      issue(3, pack(15, 15, 15, 15), 1'b0);
      issue(1, pack(15, 15, 15, 15), 1'b0);
      issue(2, pack(2, 9, 7, 1), 1'b1);
      for (int m = 0; m < 4; m++) issue(m, '0, 1'b0);

      // Start pulsed mid-accumulation, then a start held in the done cycle.
      issue(0, rand_vec(), 1'b0);
      idle(1);
      spurious_start();
      issue(3, rand_vec(), 1'b0);

      // Reset during the square-root phase.
      issue(1, pack(15, 14, 13, 12), 1'b0);
      idle(L + 2);
      reset = 1'b1;
      @(posedge clk); #1;
      q.delete();
      norm_exp  = 0;
      reset     = 1'b0;
      last_done = cyc;
      idle(2);
      issue(1, pack(1, 1, 1, 1), 1'b0);

      for (int n = 0; n < 1000; n++) begin
         int m;
         logic [N-1:0] v;
         m = $urandom_range(0, 3);
         case ($urandom_range(0, 9))
            0:       v = '0;
            1:       v = {N{1'b1}};
            default: v = rand_vec();
         endcase
         issue(m, v, ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) begin
            idle($urandom_range(0, 2));
            spurious_start();
         end
         if ($urandom_range(0, 2) == 0) begin
            while (cyc < last_done) begin
               @(posedge clk); #1;
            end
            idle($urandom_range(0, 3));
         end
      end

      wait_cnt = 0;
      while (q.size() != 0 && wait_cnt < 200) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results still outstanding, expected 0", q.size());
      end
      idle(20);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_norm_multi.md
VECTOR_NORM_MULTI -- requirements
Module: vector_norm_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 4: unsigned bits per lane, 2..16.
REQ-002 SHALL have parameter LANES, default 4: lane count, 2..16.
REQ-003 SHALL derive localparams:
- LANE_BITS = $clog2(LANES)
- SUM_BITS = 2*WIDTH + LANE_BITS
- ROOT_BITS = ceil(SUM_BITS/2)
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports, in this order:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  request pulse, sampled only in IDLE
- mode  input  2  0=L1, 1=L2, 2=Linf, 3=squared L2
- V_in  input  LANES*WIDTH  lane i = V_in[(i+1)*WIDTH-1 : i*WIDTH]
- busy  output  1  operation in progress
- norm_out  output  SUM_BITS  result, zero-extended
- done  output  1  one-cycle result strobe

Function
REQ-006 SHALL implement states IDLE, ACCUM and SQRT; unused encodings SHALL go to IDLE on the next edge.
REQ-007 In IDLE with start=1 at edge k, SHALL:
- capture V_in and mode into internal registers;
- clear the accumulator and lane index;
- enter ACCUM.
REQ-008 After capture, SHALL ignore changes on V_in and mode until the next accepted start.
REQ-009 ACCUM SHALL process one lane per cycle, lane 0 first, for exactly LANES cycles (edges k+1..k+LANES).
REQ-010 Per-lane accumulator update, by captured mode:
- mode 0: add lane value;
- modes 1 and 3: add lane squared;
- mode 2: keep the maximum.
All arithmetic is unsigned, SUM_BITS wide, and SHALL never overflow.
REQ-011 After the last lane, modes 0, 2 and 3 SHALL load norm_out with the accumulator and pulse done at edge k+LANES+1, returning to IDLE.
REQ-012 After the last lane, mode 1 SHALL enter SQRT and load:
- remainder = sum of squares;
- root = 0;
- bit = 1 << (2*ROOT_BITS-2).
REQ-013 SQRT SHALL run ROOT_BITS restoring-bit iterations, one per cycle:
- if remainder >= root+bit: remainder -= root+bit, then root = (root>>1)+bit;
- else root = root>>1;
- in both cases bit >>= 2.
REQ-014 Mode 1 SHALL finish at edge k+LANES+ROOT_BITS+1:
- norm_out = floor(sqrt(sum of squares)), zero-extended;
- done pulses; return to IDLE.
REQ-015 done SHALL be high for exactly one cycle per accepted start.
REQ-016 norm_out SHALL change only on the done edge and SHALL hold its value until the next done.
REQ-017 busy SHALL be high from edge k+1 through the cycle before done, and low in the done cycle.
REQ-018 start while busy SHALL be ignored, with no effect on state, captured data or outputs.
REQ-019 start in the done cycle SHALL be accepted (state is IDLE), giving back-to-back operation with no idle gap.
REQ-020 All-zero input SHALL yield norm_out=0 in every mode.
REQ-021 Max-value lanes SHALL yield:
- mode 3: LANES*(2^WIDTH-1)^2;
- mode 0: LANES*(2^WIDTH-1).

Reset
REQ-022 reset=1 at any edge SHALL force:
- state IDLE;
- busy=0, done=0, norm_out=0;
- accumulator, index, remainder, root, bit and captured registers = 0.
REQ-023 reset SHALL override start on the same edge.
REQ-024 Reset mid-operation SHALL abort with no done pulse; a start after reset deasserts SHALL behave as from power-up.

Verification (WIDTH=4, LANES=4: SUM_BITS=10, ROOT_BITS=5)
REQ-025 mode=1, lanes {3,4,0,0} -> done 10 cycles after the start edge, norm_out=5, busy high for 9 cycles.
REQ-026 mode=0, lanes {15,15,15,15} -> norm_out=60 at 5 cycles; then mode=3 on the same data -> 900; then mode=1 -> 30.
REQ-027 mode=2, lanes {2,9,7,1} -> norm_out=9 at 5 cycles. In the same run, V_in changed to all 15 one cycle after start -> still 9.
REQ-028 Second start pulsed mid-ACCUM -> exactly one done with the first result. start asserted in the done cycle -> second result follows with no gap.
REQ-029 reset asserted during SQRT -> no done, norm_out=0, busy=0. A new mode=1 start on {1,1,1,1} -> norm_out=2.
REQ-030 Randomised modes and data over 1000 operations SHALL match a reference model for value and latency exactly.
